// File: rtl/load_master_pattern_param.sv
// Master-pattern loader: collects one shape code per slot and freezes the
// pattern once every slot is filled; rejected load requests pulse loadError.
module load_master_pattern_param #(
    parameter int unsigned NUM_SLOTS       = 4,
    parameter int unsigned SHAPE_W         = 3,
    parameter int unsigned MAX_SHAPE       = 6,
    parameter bit          ALLOW_OVERWRITE = 1'b1,
    localparam int unsigned LOC_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1,
    localparam int unsigned CNT_W = $clog2(NUM_SLOTS + 1)
) (
    input  logic                         clock,
    input  logic                         reset_L,
    input  logic                         startGame,
    input  logic                         loadingShape,
    input  logic [SHAPE_W-1:0]           LoadShape,
    input  logic [LOC_W-1:0]             ShapeLocation,
    output logic [NUM_SLOTS*SHAPE_W-1:0] masterPattern,
    output logic [NUM_SLOTS-1:0]         slotFilled,
    output logic [CNT_W-1:0]             slotsFilledCount,
    output logic                         masterLoaded,
    output logic                         loadError
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] LOADING = 2'd1;
    localparam logic [1:0] LOADED  = 2'd2;

    logic [1:0]                   stateQ, stateD;
    logic [NUM_SLOTS*SHAPE_W-1:0] patternQ, patternD;
    logic [NUM_SLOTS-1:0]         filledQ, filledD;
    logic [CNT_W-1:0]             countQ, countD;
    logic                         errorQ, errorD;

    logic [31:0] shapeWide, locWide;
    logic        shapeLegal, locLegal, slotFree, loadOk;

    assign shapeWide  = 32'(LoadShape);
    assign locWide    = 32'(ShapeLocation);
    assign shapeLegal = (shapeWide >= 32'd1) && (shapeWide <= MAX_SHAPE);
    // Only reachable as false when NUM_SLOTS is not a power of two.
    assign locLegal   = locWide < NUM_SLOTS;

    always_comb begin
        slotFree = 1'b0;
        for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
            if (locWide == i) begin
                slotFree = ~filledQ[i];
            end
        end
    end

    assign loadOk = shapeLegal && locLegal && (ALLOW_OVERWRITE || slotFree);

    always_comb begin
        stateD   = stateQ;
        patternD = patternQ;
        filledD  = filledQ;
        errorD   = 1'b0;
        case (stateQ)
            IDLE: begin
                if (startGame) begin
                    patternD = '0;
                    filledD  = '0;
                    stateD   = LOADING;
                end
            end
            LOADING: begin
                if (startGame) begin
                    patternD = '0;
                    filledD  = '0;
                end else if (loadingShape) begin
                    if (loadOk) begin
                        for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
                            if (locWide == i) begin
                                patternD[i*SHAPE_W +: SHAPE_W] = LoadShape;
                                filledD[i]                     = 1'b1;
                            end
                        end
                        if (&filledD) begin
                            stateD = LOADED;
                        end
                    end else begin
                        errorD = 1'b1;
                    end
                end
            end
            LOADED: begin
                if (startGame) begin
                    patternD = '0;
                    filledD  = '0;
                    stateD   = LOADING;
                end else if (loadingShape) begin
                    errorD = 1'b1;
                end
            end
            default: begin
                stateD   = IDLE;
                patternD = '0;
                filledD  = '0;
            end
        endcase
    end

    // Count is registered alongside filledQ so both move on the same edge.
    always_comb begin
        countD = '0;
        for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
            countD = countD + CNT_W'(filledD[i]);
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_L) begin
            stateQ   <= IDLE;
            patternQ <= '0;
            filledQ  <= '0;
            countQ   <= '0;
            errorQ   <= 1'b0;
        end else begin
            stateQ   <= stateD;
            patternQ <= patternD;
            filledQ  <= filledD;
            countQ   <= countD;
            errorQ   <= errorD;
        end
    end

    assign masterPattern    = patternQ;
    assign slotFilled       = filledQ;
    assign slotsFilledCount = countQ;
    assign masterLoaded     = (stateQ == LOADED);
    assign loadError        = errorQ;

endmodule

// File: tb/tb_load_master_pattern_param.sv
// Drives three loader configurations (default, no-overwrite, three slots) from one
// stimulus stream and compares each against a slot-array model through a queue.
module tb_load_master_pattern_param;

    logic       clock = 1'b0;
    logic       reset_L, startGame, loadingShape;
    logic [2:0] LoadShape;
    logic [1:0] ShapeLocation;

    logic [11:0] patA, patB;
    logic [8:0]  patC;
    logic [3:0]  filA, filB;
    logic [2:0]  filC;
    logic [2:0]  cntA, cntB;
    logic [1:0]  cntC;
    logic [2:0]  ldd, err;

    always #5 clock = ~clock;

    load_master_pattern_param u_dutA (
        .clock(clock), .reset_L(reset_L), .startGame(startGame),
        .loadingShape(loadingShape), .LoadShape(LoadShape), .ShapeLocation(ShapeLocation),
        .masterPattern(patA), .slotFilled(filA), .slotsFilledCount(cntA),
        .masterLoaded(ldd[0]), .loadError(err[0])
    );

    load_master_pattern_param #(.ALLOW_OVERWRITE(1'b0)) u_dutB (
        .clock(clock), .reset_L(reset_L), .startGame(startGame),
        .loadingShape(loadingShape), .LoadShape(LoadShape), .ShapeLocation(ShapeLocation),
        .masterPattern(patB), .slotFilled(filB), .slotsFilledCount(cntB),
        .masterLoaded(ldd[1]), .loadError(err[1])
    );

    load_master_pattern_param #(.NUM_SLOTS(3)) u_dutC (
        .clock(clock), .reset_L(reset_L), .startGame(startGame),
        .loadingShape(loadingShape), .LoadShape(LoadShape), .ShapeLocation(ShapeLocation),
        .masterPattern(patC), .slotFilled(filC), .slotsFilledCount(cntC),
        .masterLoaded(ldd[2]), .loadError(err[2])
    );

    typedef struct packed {
        logic [2:0][11:0] pat;
        logic [2:0][3:0]  fil;
        logic [2:0][2:0]  cnt;
        logic [2:0]       ldd;
        logic [2:0]       err;
    } exp_t;

    exp_t expQ[$];
    int   checks = 0;
    int   failures = 0;

    // Reference model: per configuration, an array of slot contents and flags.
    int cfgSlots[3] = '{4, 4, 3};
    bit cfgOw[3]    = '{1'b1, 1'b0, 1'b1};
    int mSlot[3][4];
    bit mFill[3][4];
    bit mActive[3];
    bit mLoaded[3];
    bit mErr[3];

    task automatic clearSlots(input int k);
        for (int i = 0; i < 4; i++) begin
            mSlot[k][i] = 0;
            mFill[k][i] = 1'b0;
        end
    endtask

    task automatic modelStep(input bit r, input bit s, input bit l, input int shp,
                             input int loc);
        bit ok;
        bit full;
        for (int k = 0; k < 3; k++) begin
            mErr[k] = 1'b0;
            if (!r) begin
                clearSlots(k);
                mActive[k] = 1'b0;
                mLoaded[k] = 1'b0;
            end else if (s) begin
                clearSlots(k);
                mActive[k] = 1'b1;
                mLoaded[k] = 1'b0;
            end else if (mLoaded[k]) begin
                mErr[k] = l;
            end else if (mActive[k] && l) begin
                ok = (shp >= 1) && (shp <= 6) && (loc < cfgSlots[k]);
                if (ok && !cfgOw[k] && mFill[k][loc]) ok = 1'b0;
                if (ok) begin
                    mSlot[k][loc] = shp;
                    mFill[k][loc] = 1'b1;
                    full = 1'b1;
                    for (int i = 0; i < cfgSlots[k]; i++) if (!mFill[k][i]) full = 1'b0;
                    if (full) begin
                        mActive[k] = 1'b0;
                        mLoaded[k] = 1'b1;
                    end
                end else begin
                    mErr[k] = 1'b1;
                end
            end
        end
    endtask

    function automatic exp_t snapshot();
        exp_t e;
        int   c;
        e = '0;
        for (int k = 0; k < 3; k++) begin
            c = 0;
            for (int i = 0; i < cfgSlots[k]; i++) begin
                e.pat[k] = e.pat[k] | (12'(mSlot[k][i]) << (3 * i));
                e.fil[k][i] = mFill[k][i];
                c += int'(mFill[k][i]);
            end
            e.cnt[k] = 3'(c);
            e.ldd[k] = mLoaded[k];
            e.err[k] = mErr[k];
        end
        return e;
    endfunction

    task automatic cycle(input bit r, input bit s, input bit l, input int shp, input int loc);
        @(negedge clock);
        reset_L       = r;
        startGame     = s;
        loadingShape  = l;
        LoadShape     = 3'(shp);
        ShapeLocation = 2'(loc);
        modelStep(r, s, l, shp, loc);
        expQ.push_back(snapshot());
    endtask

    task automatic check(input string name, input int k, input logic [11:0] act,
                         input logic [11:0] want);
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL %s dut%0d at %0t: got %h expected %h", name, k, $time, act, want);
        end
    endtask

    // Monitor: outputs are registered and valid every cycle, so pop once per edge.
    initial begin
        exp_t e;
        logic [2:0][11:0] aPat;
        logic [2:0][3:0]  aFil;
        logic [2:0][2:0]  aCnt;
        forever begin
            @(posedge clock);
            #2;
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                aPat = {{3'b0, patC}, patB, patA};
                aFil = {{1'b0, filC}, filB, filA};
                aCnt = {{1'b0, cntC}, cntB, cntA};
                for (int k = 0; k < 3; k++) begin
                    check("masterPattern", k, aPat[k], e.pat[k]);
                    check("slotFilled", k, 12'(aFil[k]), 12'(e.fil[k]));
                    check("slotsFilledCount", k, 12'(aCnt[k]), 12'(e.cnt[k]));
                    check("masterLoaded", k, 12'(ldd[k]), 12'(e.ldd[k]));
                    check("loadError", k, 12'(err[k]), 12'(e.err[k]));
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        cycle(0, 0, 0, 0, 0);
        cycle(0, 1, 1, 1, 0);
        cycle(1, 0, 1, 1, 0);   // IDLE ignores loads
        cycle(1, 1, 0, 0, 0);
        cycle(1, 0, 1, 1, 0);
        cycle(1, 0, 1, 2, 1);
        cycle(1, 0, 1, 3, 2);
        cycle(1, 0, 1, 4, 3);
        cycle(1, 0, 0, 0, 0);
        cycle(1, 0, 1, 1, 0);   // load while LOADED
        cycle(1, 0, 0, 0, 0);
        cycle(1, 1, 0, 0, 0);
        cycle(1, 0, 1, 0, 1);
        cycle(1, 0, 0, 0, 0);
        cycle(1, 0, 1, 7, 1);
        cycle(1, 0, 0, 0, 0);
        cycle(1, 0, 1, 5, 2);
        cycle(1, 0, 1, 6, 2);   // overwrite
        cycle(1, 0, 0, 0, 0);
        cycle(1, 1, 1, 3, 0);   // start beats load
        cycle(1, 0, 0, 0, 0);
        cycle(1, 0, 1, 1, 3);   // out of range for three slots
        cycle(1, 0, 1, 1, 0);
        cycle(1, 0, 1, 2, 1);
        cycle(1, 0, 1, 3, 2);
        cycle(1, 0, 0, 0, 0);
        cycle(1, 1, 0, 0, 0);
        cycle(1, 0, 1, 5, 1);
        cycle(0, 1, 1, 2, 0);   // reset mid-load wins
        cycle(1, 0, 0, 0, 0);
        cycle(1, 1, 0, 0, 0);
        for (int n = 0; n < 3000; n++) begin
            cycle($urandom_range(0, 63) != 0, $urandom_range(0, 15) == 0,
                  $urandom_range(0, 9) < 7, int'($urandom_range(0, 7)),
                  int'($urandom_range(0, 3)));
        end
        repeat (3) @(negedge clock);
        checks++;
        if (expQ.size() != 0) begin
            failures++;
            $display("FAIL queue_drain: %0d entries left, expected 0", expQ.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
